frame_sync_controller: RTL and testbench



---
 rtl/frame_sync_pkg.sv | 14 +
 rtl/sync_pattern_matcher.sv | 37 +++
 rtl/frame_sync_controller.sv | 135 +++++++++++++
 tb/tb_frame_sync_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sync_pkg.sv
// Shared types and helpers for the serial frame synchroniser.
package frame_sync_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic int payload_len(input int frame_len, input int pat_w);
    return frame_len - pat_w;
  endfunction

endpackage

// File: rtl/sync_pattern_matcher.sv
// Bit history and fill tracking; flags when the newest PAT_W bits equal the pattern.
module sync_pattern_matcher #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0] hist_r;
  logic [FILL_W-1:0] fill_r;
  logic [PAT_W-1:0] window_s;

  assign window_s = {hist_r, in};

  // shift in accepted bits; fill saturates so a full window is known to exist
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (en) begin
      hist_r <= window_s[PAT_W-2:0];
      if (fill_r != FILL_MAX) begin
        fill_r <= fill_r + FILL_W'(1);
      end
    end
  end

  assign match = (window_s == pattern) && (fill_r == FILL_MAX);

endmodule

// File: rtl/frame_sync_controller.sv
// Frame synchroniser: hunt, verify and flywheel lock on a repeating sync pattern,
// tagging payload bits with their index while locked.
module frame_sync_controller
  import frame_sync_pkg::*;
#(
  parameter int PAT_W     = 4,
  parameter int FRAME_LEN = 16,
  parameter int LOCK_CNT  = 2,
  parameter int MISS_CNT  = 2,
  parameter int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in,
  input  logic [PAT_W-1:0] pattern,
  output logic             sync_hit,
  output logic             locked,
  output logic             payload_valid,
  output logic             payload_bit,
  output logic [IDX_W-1:0] bit_idx,
  output logic             frame_start
);

  localparam int HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(MISS_CNT + 1);
  localparam logic [IDX_W-1:0]  POS_LAST  = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0]  PAY_END   = IDX_W'(payload_len(FRAME_LEN, PAT_W));
  localparam logic [HIT_W-1:0]  LOCK_LAST = HIT_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_CNT - 1);

  state_e            state_r;
  logic [IDX_W-1:0]  pos_r;
  logic [HIT_W-1:0]  hit_cnt_r;
  logic [MISS_W-1:0] miss_cnt_r;
  logic              match_s;

  sync_pattern_matcher #(
    .PAT_W(PAT_W)
  ) u_matcher (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .in     (in),
    .pattern(pattern),
    .match  (match_s)
  );

  // lock state machine, frame position, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= HUNT;
      pos_r         <= '0;
      hit_cnt_r     <= '0;
      miss_cnt_r    <= '0;
      sync_hit      <= 1'b0;
      locked        <= 1'b0;
      payload_valid <= 1'b0;
      payload_bit   <= 1'b0;
      bit_idx       <= '0;
      frame_start   <= 1'b0;
    end else begin
      sync_hit      <= 1'b0;
      payload_valid <= 1'b0;
      frame_start   <= 1'b0;
      if (en) begin
        case (state_r)
          HUNT: begin
            if (match_s) begin
              sync_hit  <= 1'b1;
              pos_r     <= '0;
              hit_cnt_r <= HIT_W'(1);
              if (LOCK_CNT == 1) begin
                state_r    <= LOCKED;
                locked     <= 1'b1;
                miss_cnt_r <= '0;
              end else begin
                state_r <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (pos_r == POS_LAST) begin
              pos_r <= '0;
              if (match_s) begin
                sync_hit  <= 1'b1;
                hit_cnt_r <= hit_cnt_r + HIT_W'(1);
                if (hit_cnt_r == LOCK_LAST) begin
                  state_r    <= LOCKED;
                  locked     <= 1'b1;
                  miss_cnt_r <= '0;
                end
              end else begin
                state_r   <= HUNT;
                hit_cnt_r <= '0;
              end
            end else begin
              pos_r <= pos_r + IDX_W'(1);
            end
          end
          LOCKED: begin
            if (pos_r < PAY_END) begin
              payload_valid <= 1'b1;
              payload_bit   <= in;
              bit_idx       <= pos_r;
              frame_start   <= (pos_r == {IDX_W{1'b0}});
            end
            // position wraps on hit or miss so frame timing survives a bad sync
            if (pos_r == POS_LAST) begin
              pos_r <= '0;
              if (match_s) begin
                sync_hit   <= 1'b1;
                miss_cnt_r <= '0;
              end else if (miss_cnt_r == MISS_LAST) begin
                state_r    <= HUNT;
                locked     <= 1'b0;
                miss_cnt_r <= '0;
                hit_cnt_r  <= '0;
              end else begin
                miss_cnt_r <= miss_cnt_r + MISS_W'(1);
              end
            end else begin
              pos_r <= pos_r + IDX_W'(1);
            end
          end
          default: begin
            state_r <= HUNT;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_sync_controller.sv
// Scoreboard bench for frame_sync_controller with PAT_W=4, FRAME_LEN=8, LOCK_CNT=2, MISS_CNT=2.
module tb_frame_sync_controller;

  localparam int PAT_W     = 4;
  localparam int FRAME_LEN = 8;
  localparam int LOCK_CNT  = 2;
  localparam int MISS_CNT  = 2;
  localparam int IDX_W     = 3;

  typedef struct packed {
    logic             sh;
    logic             lk;
    logic             pv;
    logic             pb;
    logic [IDX_W-1:0] idx;
    logic             fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic din;
  logic [PAT_W-1:0] pattern;
  logic sync_hit, locked, payload_valid, payload_bit, frame_start;
  logic [IDX_W-1:0] bit_idx;

  int n_vec = 0;
  int n_err = 0;
  int n_hits = 0;
  exp_t sb_q[$];

  // reference model state
  int   m_state, m_nbits, m_pos, m_hit, m_miss;
  logic [PAT_W-1:0] m_hist;
  logic m_locked;

  frame_sync_controller #(
    .PAT_W(PAT_W), .FRAME_LEN(FRAME_LEN), .LOCK_CNT(LOCK_CNT), .MISS_CNT(MISS_CNT), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in(din), .pattern(pattern),
    .sync_hit(sync_hit), .locked(locked), .payload_valid(payload_valid),
    .payload_bit(payload_bit), .bit_idx(bit_idx), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_nbits = 0; m_pos = 0; m_hit = 0; m_miss = 0;
    m_hist = '0; m_locked = 1'b0;
  endtask

  task automatic model_bit(input logic b, output exp_t x);
    logic mt;
    x = '0;
    m_hist = {m_hist[PAT_W-2:0], b};
    if (m_nbits < PAT_W) m_nbits++;
    mt = (m_hist == pattern) && (m_nbits >= PAT_W);
    if (m_state == 0) begin
      if (mt) begin
        x.sh = 1'b1; m_pos = 0; m_hit = 1;
        if (LOCK_CNT == 1) begin m_state = 2; m_locked = 1'b1; m_miss = 0; end
        else m_state = 1;
      end
    end else if (m_state == 1) begin
      if (m_pos == FRAME_LEN - 1) begin
        m_pos = 0;
        if (mt) begin
          x.sh = 1'b1; m_hit++;
          if (m_hit == LOCK_CNT) begin m_state = 2; m_locked = 1'b1; m_miss = 0; end
        end else begin
          m_state = 0; m_hit = 0;
        end
      end else m_pos++;
    end else begin
      if (m_pos < FRAME_LEN - PAT_W) begin
        x.pv = 1'b1; x.pb = b; x.idx = IDX_W'(m_pos); x.fs = (m_pos == 0);
      end
      if (m_pos == FRAME_LEN - 1) begin
        m_pos = 0;
        if (mt) begin x.sh = 1'b1; m_miss = 0; end
        else begin
          m_miss++;
          if (m_miss == MISS_CNT) begin m_state = 0; m_locked = 1'b0; m_miss = 0; end
        end
      end else m_pos++;
    end
    x.lk = m_locked;
  endtask

  task automatic compare_out();
    exp_t x;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      x = sb_q.pop_front();
      if (sync_hit === 1'b1) n_hits++;
      check_val("sync_hit", 32'(sync_hit), 32'(x.sh));
      check_val("locked", 32'(locked), 32'(x.lk));
      check_val("payload_valid", 32'(payload_valid), 32'(x.pv));
      check_val("frame_start", 32'(frame_start), 32'(x.fs));
      if (x.pv) begin
        check_val("payload_bit", 32'(payload_bit), 32'(x.pb));
        check_val("bit_idx", 32'(bit_idx), 32'(x.idx));
      end
    end
  endtask

  task automatic step(input logic e, input logic b);
    exp_t x;
    @(negedge clk);
    en = e;
    din = b;
    if (e) model_bit(b, x);
    else begin
      x = '0;
      x.lk = m_locked;
    end
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic send(input logic [15:0] bits, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps && ($urandom_range(0, 2) == 0)) step(1'b0, 1'($urandom_range(0, 1)));
      step(1'b1, bits[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_hits = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; din = 1'b0; pattern = 4'b1101;
    model_reset();

    // reset held with a toggling input: all outputs stay low
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en = 1'b1;
      din = ~din;
      @(posedge clk);
      #1;
      check_val("rst_outputs",
                32'({sync_hit, locked, payload_valid, payload_bit, bit_idx, frame_start}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(16'b110, 3, 1'b0);
    check_val("rst_no_early_hit", 32'(n_hits), 32'd0);

    // acquire and first payload frame
    do_reset();
    send(16'b1101_0110_1101_1010, 16, 1'b0);
    check_val("acq_hits", 32'(n_hits), 32'd2);
    check_val("acq_locked", 32'(locked), 32'd1);

    // false sync: payload emulates the pattern, then the sync slot misses
    do_reset();
    send(16'b1101_1101_0000, 12, 1'b0);
    check_val("false_hits", 32'(n_hits), 32'd1);
    check_val("false_locked", 32'(locked), 32'd0);

    // flywheel through an isolated miss, then drop after two consecutive misses
    do_reset();
    send(16'b1101_0110_1101, 12, 1'b0);
    send(16'b1010_1001, 8, 1'b0);
    check_val("fly_hold1", 32'(locked), 32'd1);
    send(16'b0011_1101, 8, 1'b0);
    send(16'b1111_1001, 8, 1'b0);
    check_val("fly_hold2", 32'(locked), 32'd1);
    send(16'b0000_000, 7, 1'b0);
    check_val("fly_before_drop", 32'(locked), 32'd1);
    step(1'b1, 1'b0);
    check_val("fly_drop", 32'(locked), 32'd0);

    // acquire stream again with random en gaps
    do_reset();
    send(16'b1101_0110_1101_1010, 16, 1'b1);
    send(16'b1101_0101, 8, 1'b1);
    check_val("gap_locked", 32'(locked), 32'd1);

    // asynchronous reset while locked at bit_idx 2
    do_reset();
    send(16'b1101_0110_1101_101, 15, 1'b0);
    check_val("mid_idx", 32'(bit_idx), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_locked", 32'(locked), 32'd0);
    check_val("mid_rst_pv", 32'(payload_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sb_q.delete();
    send(16'b1101_0110, 8, 1'b0);
    check_val("mid_one_sync", 32'(locked), 32'd0);
    send(16'b1101, 4, 1'b0);
    check_val("mid_relock", 32'(locked), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
